// File: rtl/sn_uart_rx_ctrl.sv
// Frame sequencer for sn_uart_rx: collects header/addr/data/checksum frames
// and issues single-cycle writes on the neuron config bus.
module sn_uart_rx_ctrl #(
   parameter int unsigned P_DATA_BYTES   = 2,
   parameter logic [7:0]  P_HEADER       = 8'hA5,
   parameter int unsigned P_TIMEOUT_CLKS = 2000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ctrl_enable,
   output logic                      rx_enable,
   input  logic [7:0]                received_word,
   input  logic                      rx_done,
   input  logic                      rx_active,
   output logic                      cfg_wr_en,
   output logic [7:0]                cfg_addr,
   output logic [8*P_DATA_BYTES-1:0] cfg_wr_data,
   output logic                      frame_err,
   output logic [7:0]                err_count,
   output logic                      busy
);

   localparam int unsigned DW = 8 * P_DATA_BYTES;
   localparam int unsigned TW = $clog2(P_TIMEOUT_CLKS + 1);
   localparam int unsigned BW = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_HUNT, S_ADDR, S_DATA, S_CHK, S_COMMIT
   } state_t;

   state_t          state, state_next;
   logic [TW-1:0]   tmo_cnt;
   logic [BW-1:0]   byte_cnt;
   logic [7:0]      chk;
   logic [7:0]      addr_sh;
   logic [DW-1:0]   data_sh;
   logic            in_frame_c, tmo_hit_c, commit_c, err_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next state, commit and error decisions; a disable aborts silently
   always_comb begin
      state_next = state;
      commit_c   = 1'b0;
      err_c      = 1'b0;
      in_frame_c = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
      tmo_hit_c  = in_frame_c && !rx_done && (tmo_cnt == TW'(P_TIMEOUT_CLKS - 1));
      case (state)
         S_IDLE: if (ctrl_enable) state_next = S_HUNT;
         S_HUNT: begin
            if (!ctrl_enable) begin
               if (!rx_active || rx_done) state_next = S_IDLE;
            end else if (rx_done && received_word == P_HEADER) begin
               state_next = S_ADDR;
            end
         end
         S_ADDR, S_DATA, S_CHK: begin
            if (!ctrl_enable) begin
               state_next = S_IDLE;
            end else if (rx_done) begin
               if (state == S_ADDR) begin
                  state_next = S_DATA;
               end else if (state == S_DATA) begin
                  if (byte_cnt == BW'(P_DATA_BYTES - 1)) state_next = S_CHK;
               end else if (received_word == chk) begin
                  commit_c   = 1'b1;
                  state_next = S_COMMIT;
               end else begin
                  err_c      = 1'b1;
                  state_next = S_HUNT;
               end
            end else if (tmo_hit_c) begin
               err_c      = 1'b1;
               state_next = S_HUNT;
            end
         end
         S_COMMIT: state_next = ctrl_enable ? S_HUNT : S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Registered outputs, shadows and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_enable   <= 1'b0;
         busy        <= 1'b0;
         cfg_wr_en   <= 1'b0;
         frame_err   <= 1'b0;
         err_count   <= '0;
         cfg_addr    <= '0;
         cfg_wr_data <= '0;
         tmo_cnt     <= '0;
         byte_cnt    <= '0;
         chk         <= '0;
         addr_sh     <= '0;
         data_sh     <= '0;
      end else begin
         rx_enable <= (state_next != S_IDLE);
         busy      <= (state_next != S_IDLE) && (state_next != S_HUNT);
         cfg_wr_en <= commit_c;
         frame_err <= err_c;
         if (err_c && err_count != 8'hFF) err_count <= err_count + 8'd1;
         if (commit_c) begin
            cfg_addr    <= addr_sh;
            cfg_wr_data <= data_sh;
         end
         tmo_cnt <= (in_frame_c && !rx_done) ? tmo_cnt + TW'(1) : '0;
         if (rx_done) begin
            if (state == S_ADDR) begin
               addr_sh  <= received_word;
               chk      <= received_word;
               byte_cnt <= '0;
            end else if (state == S_DATA) begin
               data_sh  <= (data_sh << 8) | DW'(received_word);
               chk      <= chk ^ received_word;
               byte_cnt <= byte_cnt + BW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sn_uart_rx_ctrl.sv
// Self-checking bench for sn_uart_rx_ctrl: frame-level reference model compared
// every cycle, plus directed literal checks on the test-plan scenarios.
module tb_sn_uart_rx_ctrl;
   localparam int unsigned P = 2;
   localparam int unsigned T = 2000;

   logic        clk = 1'b0;
   logic        rst, ctrl_enable, rx_done, rx_active;
   logic [7:0]  received_word;
   logic        rx_enable, cfg_wr_en, frame_err, busy;
   logic [7:0]  cfg_addr, err_count;
   logic [15:0] cfg_wr_data;

   always #5 clk = ~clk;

   sn_uart_rx_ctrl #(.P_DATA_BYTES(P), .P_HEADER(8'hA5), .P_TIMEOUT_CLKS(T)) dut (
      .clk(clk), .rst(rst), .ctrl_enable(ctrl_enable), .rx_enable(rx_enable),
      .received_word(received_word), .rx_done(rx_done), .rx_active(rx_active),
      .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data),
      .frame_err(frame_err), .err_count(err_count), .busy(busy)
   );

   int n_tests = 0, n_fail = 0;
   int cyc = 0, wr_seen = 0, err_seen = 0, wr_cyc = -1, done_cyc = -1;

   // Reference model: "on", "in a frame" (bytes after header), pending commit cycle
   bit          m_on, m_hdr, m_commit;
   logic [7:0]  m_buf[$];
   int          m_idle;
   logic        e_wr, e_err, e_rxen, e_busy;
   logic [7:0]  e_addr, e_cnt;
   logic [15:0] e_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_on = 0; m_hdr = 0; m_commit = 0; m_idle = 0; m_buf.delete();
      e_wr = 0; e_err = 0; e_rxen = 0; e_busy = 0;
      e_addr = '0; e_cnt = '0; e_data = '0;
   endtask

   task automatic model_edge();
      logic [7:0] x;
      e_wr = 0; e_err = 0;
      if (!m_on) begin
         if (ctrl_enable) m_on = 1;
      end else if (m_commit) begin
         m_commit = 0;
         if (!ctrl_enable) m_on = 0;
      end else if (!m_hdr) begin
         if (!ctrl_enable) begin
            if (!rx_active || rx_done) m_on = 0;
         end else if (rx_done && received_word == 8'hA5) begin
            m_hdr = 1; m_idle = 0; m_buf.delete();
         end
      end else begin
         if (!ctrl_enable) begin
            m_hdr = 0; m_on = 0;
         end else if (rx_done) begin
            m_idle = 0;
            m_buf.push_back(received_word);
            if (m_buf.size() == P + 2) begin
               x = m_buf[0];
               for (int i = 1; i <= P; i++) x = x ^ m_buf[i];
               m_hdr = 0;
               if (x == m_buf[P+1]) begin
                  e_wr = 1; m_commit = 1; e_addr = m_buf[0]; e_data = '0;
                  for (int i = 1; i <= P; i++) e_data = (e_data << 8) | 16'(m_buf[i]);
               end else begin
                  e_err = 1;
               end
            end
         end else begin
            m_idle++;
            if (m_idle == T) begin e_err = 1; m_hdr = 0; end
         end
      end
      if (e_err && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
      e_rxen = m_on;
      e_busy = m_on && (m_hdr || m_commit);
   endtask

   task automatic compare_all();
      check("rx_enable",   32'(rx_enable),   32'(e_rxen));
      check("busy",        32'(busy),        32'(e_busy));
      check("cfg_wr_en",   32'(cfg_wr_en),   32'(e_wr));
      check("frame_err",   32'(frame_err),   32'(e_err));
      check("err_count",   32'(err_count),   32'(e_cnt));
      check("cfg_addr",    32'(cfg_addr),    32'(e_addr));
      check("cfg_wr_data", 32'(cfg_wr_data), 32'(e_data));
   endtask

   // One clock: model advances on the edge, DUT sampled on the falling edge
   task automatic step();
      @(posedge clk);
      cyc++;
      if (rst) model_reset(); else model_edge();
      @(negedge clk);
      if (cfg_wr_en) begin wr_seen++; wr_cyc = cyc; end
      if (frame_err) err_seen++;
      if (!rst) compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_active = 1; step(); step();
      rx_done = 1; received_word = b; rx_active = 0;
      step(); done_cyc = cyc;
      rx_done = 0; step(); step();
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] d0,
                             input logic [7:0] d1, input logic [7:0] c);
      send_byte(8'hA5); send_byte(a); send_byte(d0); send_byte(d1); send_byte(c);
   endtask

   initial begin
      rst = 1; ctrl_enable = 0; rx_done = 0; rx_active = 0; received_word = '0;
      model_reset();
      @(negedge clk); @(negedge clk);
      check("rst_rx_enable", 32'(rx_enable), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      rst = 0;
      idle(2);
      ctrl_enable = 1;
      idle(3);

      // Good frame
      send_frame(8'h10, 8'h12, 8'h34, 8'h36);
      check("t1_wr_pulses", 32'(wr_seen), 32'd1);
      check("t1_latency", 32'(wr_cyc), 32'(done_cyc));
      check("t1_addr", 32'(cfg_addr), 32'h10);
      check("t1_data", 32'(cfg_wr_data), 32'h1234);
      check("t1_no_err", 32'(err_seen), 32'd0);

      // Bad checksum, then a good frame
      send_frame(8'h10, 8'h12, 8'h34, 8'h37);
      check("t2_err_pulses", 32'(err_seen), 32'd1);
      check("t2_err_count", 32'(err_count), 32'd1);
      check("t2_no_wr", 32'(wr_seen), 32'd1);
      check("t2_addr_kept", 32'(cfg_addr), 32'h10);
      check("t2_data_kept", 32'(cfg_wr_data), 32'h1234);
      send_frame(8'h10, 8'h55, 8'h66, 8'h23);
      check("t2_next_wr", 32'(wr_seen), 32'd2);
      check("t2_next_data", 32'(cfg_wr_data), 32'h5566);

      // Noise bytes before a frame
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      send_frame(8'h01, 8'hAB, 8'hCD, 8'h67);
      check("t3_err_count", 32'(err_count), 32'd1);
      check("t3_addr", 32'(cfg_addr), 32'h01);
      check("t3_data", 32'(cfg_wr_data), 32'hABCD);

      // Inter-byte timeout
      send_byte(8'hA5); send_byte(8'h10);
      idle(T + 5);
      check("t4_err_pulses", 32'(err_seen), 32'd2);
      check("t4_err_count", 32'(err_count), 32'd2);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_rx_enable", 32'(rx_enable), 32'd1);
      send_frame(8'h20, 8'h01, 8'h02, 8'h23);
      check("t4_addr", 32'(cfg_addr), 32'h20);
      check("t4_data", 32'(cfg_wr_data), 32'h0102);

      // Asynchronous reset mid-frame
      send_byte(8'hA5); send_byte(8'h10);
      rst = 1;
      #1;
      check("t5_rx_enable", 32'(rx_enable), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_addr", 32'(cfg_addr), 32'd0);
      check("t5_data", 32'(cfg_wr_data), 32'd0);
      check("t5_err_count", 32'(err_count), 32'd0);
      model_reset();
      step();
      rst = 0;
      idle(3);
      send_frame(8'h10, 8'h12, 8'h34, 8'h36);
      check("t5_addr_after", 32'(cfg_addr), 32'h10);
      check("t5_data_after", 32'(cfg_wr_data), 32'h1234);
      check("t5_err_after", 32'(err_count), 32'd0);

      // Disable during DATA
      wr_seen = 0; err_seen = 0;
      send_byte(8'hA5); send_byte(8'h44); send_byte(8'h12);
      ctrl_enable = 0;
      step();
      check("t6_rx_enable", 32'(rx_enable), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      idle(5);
      check("t6_no_wr", 32'(wr_seen), 32'd0);
      check("t6_no_err", 32'(err_seen), 32'd0);
      check("t6_addr_kept", 32'(cfg_addr), 32'h10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
